// File: rtl/serialtopara_pkg.sv
// Shared types and constants for the two-lane serial-to-parallel receiver.
package serialtopara_pkg;

   localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
   localparam int         BIT_CNT_W     = 3;
   localparam int         CNT_W         = 4;

   typedef enum logic [1:0] {
      SEARCH,
      ALIGNING,
      ACTIVE
   } lane_state_t;

endpackage

// File: rtl/serialtopara_rx_if.sv
// Serial inputs and recovered-byte outputs of both receiver lanes.
interface serialtopara_rx_if;

   logic       in0;
   logic       in1;
   logic [7:0] out0;
   logic [7:0] out1;
   logic       valid_0;
   logic       valid_1;
   logic       stb_0;
   logic       stb_1;
   logic       active_0;
   logic       active_1;

   modport master (
      output in0, in1,
      input  out0, out1, valid_0, valid_1, stb_0, stb_1, active_0, active_1
   );

   modport slave (
      input  in0, in1,
      output out0, out1, valid_0, valid_1, stb_0, stb_1, active_0, active_1
   );

endinterface

// File: rtl/serialtopara_lane.sv
// One receiver lane: comma search, byte alignment and data recovery.
// SERIALTOPARA_REALIGN_EN adds misaligned-comma detection that drops back to SEARCH.
module serialtopara_lane
   import serialtopara_pkg::*;
#(
   parameter logic [7:0] COMMA       = COMMA_DEFAULT,
   parameter int         COMMA_COUNT = 4
`ifdef SERIALTOPARA_REALIGN_EN
   ,
   parameter int         MISALIGN_LIMIT = 4
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
   output logic [7:0] dout,
   output logic       valid,
   output logic       stb,
   output logic       active
);

   localparam logic [CNT_W-1:0] COMMA_CNT_L = CNT_W'(COMMA_COUNT);
`ifdef SERIALTOPARA_REALIGN_EN
   localparam logic [CNT_W-1:0] MIS_LIMIT_L = CNT_W'(MISALIGN_LIMIT);
`endif

   lane_state_t          state, state_nxt;
   logic [6:0]           sr;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [CNT_W-1:0]     comma_cnt, comma_cnt_nxt;
   logic [7:0]           dout_nxt;
   logic                 valid_nxt;
   logic                 stb_nxt;
`ifdef SERIALTOPARA_REALIGN_EN
   logic [CNT_W-1:0]     mis_cnt, mis_cnt_nxt;
`endif

   logic [7:0] win;
   logic       boundary;
   logic       is_comma;

   // The newest bit completes the window, so only seven history bits are stored.
   assign win      = {sr, din};
   assign boundary = &bit_cnt;
   assign is_comma = (win == COMMA);
   assign active   = (state == ACTIVE);

   // NOTE: every next-value gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt + 1'b1;
      comma_cnt_nxt = comma_cnt;
      dout_nxt      = dout;
      valid_nxt     = valid;
      stb_nxt       = 1'b0;
`ifdef SERIALTOPARA_REALIGN_EN
      mis_cnt_nxt   = mis_cnt;
`endif
      unique case (state)
         SEARCH: begin
            if (is_comma) begin
               bit_cnt_nxt   = '0;
               comma_cnt_nxt = CNT_W'(1);
               state_nxt     = (COMMA_COUNT == 1) ? ACTIVE : ALIGNING;
            end
         end
         ALIGNING: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_cnt_nxt = comma_cnt + 1'b1;
                  if (comma_cnt + 1'b1 == COMMA_CNT_L) state_nxt = ACTIVE;
               end else begin
                  comma_cnt_nxt = '0;
                  state_nxt     = SEARCH;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               dout_nxt  = win;
               valid_nxt = !is_comma;
               stb_nxt   = 1'b1;
`ifdef SERIALTOPARA_REALIGN_EN
               if (is_comma) mis_cnt_nxt = '0;
            end else if (is_comma) begin
               // A comma off the locked phase means the stream slipped.
               if (mis_cnt + 1'b1 == MIS_LIMIT_L) begin
                  state_nxt     = SEARCH;
                  valid_nxt     = 1'b0;
                  mis_cnt_nxt   = '0;
                  comma_cnt_nxt = '0;
                  bit_cnt_nxt   = '0;
               end else begin
                  mis_cnt_nxt = mis_cnt + 1'b1;
               end
`endif
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all updates share one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         sr        <= '0;
         bit_cnt   <= '0;
         comma_cnt <= '0;
         dout      <= 8'h00;
         valid     <= 1'b0;
         stb       <= 1'b0;
`ifdef SERIALTOPARA_REALIGN_EN
         mis_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         sr        <= win[6:0];
         bit_cnt   <= bit_cnt_nxt;
         comma_cnt <= comma_cnt_nxt;
         dout      <= dout_nxt;
         valid     <= valid_nxt;
         stb       <= stb_nxt;
`ifdef SERIALTOPARA_REALIGN_EN
         mis_cnt   <= mis_cnt_nxt;
`endif
      end
   end

endmodule

// File: rtl/serialtopara_rx.sv
// Two independent serial-to-parallel lanes sharing clock and reset.
// SERIALTOPARA_REALIGN_EN enables misaligned-comma realignment in both lanes.
module serialtopara_rx
   import serialtopara_pkg::*;
#(
   parameter logic [7:0] COMMA       = COMMA_DEFAULT,
   parameter int         COMMA_COUNT = 4
`ifdef SERIALTOPARA_REALIGN_EN
   ,
   parameter int         MISALIGN_LIMIT = 4
`endif
) (
   input  logic            clk,
   input  logic            reset,
   serialtopara_rx_if.slave bus
);

   serialtopara_lane #(
      .COMMA          (COMMA),
      .COMMA_COUNT    (COMMA_COUNT)
`ifdef SERIALTOPARA_REALIGN_EN
      ,
      .MISALIGN_LIMIT (MISALIGN_LIMIT)
`endif
   ) u_lane0 (
      .clk    (clk),
      .reset  (reset),
      .din    (bus.in0),
      .dout   (bus.out0),
      .valid  (bus.valid_0),
      .stb    (bus.stb_0),
      .active (bus.active_0)
   );

   serialtopara_lane #(
      .COMMA          (COMMA),
      .COMMA_COUNT    (COMMA_COUNT)
`ifdef SERIALTOPARA_REALIGN_EN
      ,
      .MISALIGN_LIMIT (MISALIGN_LIMIT)
`endif
   ) u_lane1 (
      .clk    (clk),
      .reset  (reset),
      .din    (bus.in1),
      .dout   (bus.out1),
      .valid  (bus.valid_1),
      .stb    (bus.stb_1),
      .active (bus.active_1)
   );

endmodule

// File: tb/tb_serialtopara_rx.sv
// Self-checking bench for serialtopara_rx: directed vectors plus randomized aligned streams.
module tb_serialtopara_rx;

   localparam logic [7:0] COMMA = 8'hBC;
   localparam int         CN    = 4;
   localparam int         ND    = 6;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] e0;
      logic       v0;
      logic [7:0] e1;
      logic       v1;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] data0 [ND];
   logic [7:0] data1 [ND];
   vec_t       vecs  [6];

   serialtopara_rx_if bus ();

   serialtopara_rx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic b0, input logic b1);
      bus.in0 = b0;
      bus.in1 = b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] x0, input logic [7:0] x1, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) drive(x0[i], x1[i]);
   endtask

   task automatic send_byte(input logic [7:0] x0, input logic [7:0] x1);
      send_bits(x0, x1, 7, 0);
   endtask

   task automatic do_reset();
      bus.in0 = 1'b0;
      bus.in1 = 1'b0;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Stream: k idle zeros, CN commas, ND data bytes, then zero padding.
   function automatic logic stream_bit(input int k, input int p, input int lane);
      int         q;
      logic [7:0] b;
      if (p < k) return 1'b0;
      q = p - k;
      if (q / 8 < CN) b = COMMA;
      else if (q / 8 - CN < ND) b = (lane == 0) ? data0[q/8-CN] : data1[q/8-CN];
      else b = 8'h00;
      return b[7 - q % 8];
   endfunction

   // Expected {active, stb, valid, out} after edge t (edge 1 = first after reset).
   function automatic logic [10:0] model(input int k, input int t, input int lane);
      int         first;
      int         j;
      logic [7:0] b;
      logic       act;
      first = k + 8 * CN + 8;
      act   = (t >= k + 8 * CN);
      if (t < first) return {act, 10'b0};
      j = (t - first) / 8;
      if (j < ND) b = (lane == 0) ? data0[j] : data1[j];
      else b = 8'h00;
      return {act, ((t - first) % 8) == 0, b != COMMA, b};
   endfunction

   task automatic run_stream(input int k0, input int k1);
      do_reset();
      for (int t = 1; t <= 8 * (CN + ND + 1); t++) begin
         drive(stream_bit(k0, t - 1, 0), stream_bit(k1, t - 1, 1));
         check($sformatf("stream l0 k=%0d t=%0d", k0, t),
               {bus.active_0, bus.stb_0, bus.valid_0, bus.out0}, model(k0, t, 0));
         check($sformatf("stream l1 k=%0d t=%0d", k1, t),
               {bus.active_1, bus.stb_1, bus.valid_1, bus.out1}, model(k1, t, 1));
      end
   endtask

   function automatic logic [7:0] rand_data();
      // Values below 0x20 can never combine with neighbours into an off-phase comma.
      return ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom_range(0, 31));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] prev0, prev1;

      vecs[0] = '{8'hAA, 8'hEE, 8'hAA, 1'b1, 8'hEE, 1'b1};
      vecs[1] = '{8'hBC, 8'h55, 8'hBC, 1'b0, 8'h55, 1'b1};
      vecs[2] = '{8'h00, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'hCC, 8'hBB, 8'hCC, 1'b1, 8'hBB, 1'b1};
      vecs[4] = '{8'hBC, 8'hBC, 8'hBC, 1'b0, 8'hBC, 1'b0};
      vecs[5] = '{8'h12, 8'hBC, 8'h12, 1'b1, 8'hBC, 1'b0};

      // Reset state, then lock on four aligned commas.
      bus.in0 = 1'b0;
      bus.in1 = 1'b0;
      reset   = 1'b1;
      #12;
      check("reset outputs",
            {bus.out0, bus.out1, bus.valid_0, bus.valid_1, bus.stb_0, bus.stb_1,
             bus.active_0, bus.active_1}, 32'h0);
      do_reset();
      repeat (3) send_byte(COMMA, COMMA);
      send_bits(COMMA, COMMA, 7, 1);
      check("lock edge 31", {bus.active_0, bus.active_1}, 2'b00);
      send_bits(COMMA, COMMA, 0, 0);
      check("lock edge 32", {bus.active_0, bus.active_1, bus.stb_0, bus.stb_1}, 4'b1100);
      send_byte(COMMA, COMMA);
      check("idle strobe", {bus.stb_0, bus.stb_1, bus.valid_0, bus.valid_1, bus.out0, bus.out1},
            {4'b1100, COMMA, COMMA});

      // Table-driven data bytes on an active link.
      prev0 = {COMMA, 1'b0};
      prev1 = {COMMA, 1'b0};
      for (int i = 0; i < 6; i++) begin
         send_bits(vecs[i].b0, vecs[i].b1, 7, 4);
         check($sformatf("vec%0d hold", i), {bus.stb_0, bus.stb_1, bus.out0, bus.valid_0,
               bus.out1, bus.valid_1}, {2'b00, prev0, prev1});
         send_bits(vecs[i].b0, vecs[i].b1, 3, 0);
         check($sformatf("vec%0d lane0", i), {bus.stb_0, bus.out0, bus.valid_0},
               {1'b1, vecs[i].e0, vecs[i].v0});
         check($sformatf("vec%0d lane1", i), {bus.stb_1, bus.out1, bus.valid_1},
               {1'b1, vecs[i].e1, vecs[i].v1});
         prev0 = {vecs[i].e0, vecs[i].v0};
         prev1 = {vecs[i].e1, vecs[i].v1};
      end

      // Asynchronous reset mid-byte, then a full relock is needed.
      send_bits(8'h5A, 8'h5A, 7, 5);
      #2;
      reset = 1'b1;
      #1;
      check("async reset",
            {bus.out0, bus.out1, bus.valid_0, bus.valid_1, bus.stb_0, bus.stb_1,
             bus.active_0, bus.active_1}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) send_byte(COMMA, COMMA);
      send_bits(COMMA, COMMA, 7, 1);
      check("relock edge 31", {bus.active_0, bus.active_1}, 2'b00);
      send_bits(COMMA, COMMA, 0, 0);
      check("relock edge 32", {bus.active_0, bus.active_1}, 2'b11);

      // Broken comma run on lane 0 only.
      do_reset();
      repeat (3) send_byte(COMMA, COMMA);
      send_byte(8'h12, COMMA);
      check("bad run", {bus.active_0, bus.active_1}, 2'b01);
      send_byte(8'h00, 8'hAA);
      check("bad run after", {bus.active_0, bus.valid_0, bus.out1, bus.valid_1},
            {2'b00, 8'hAA, 1'b1});

      // One-bit slip while idle.
      do_reset();
      repeat (5) send_byte(COMMA, COMMA);
      check("slip locked", {bus.active_0, bus.active_1}, 2'b11);
      drive(1'b0, 1'b0);
      repeat (3) send_byte(COMMA, COMMA);
      send_bits(COMMA, COMMA, 7, 1);
      check("slip edge 72", {bus.active_0, bus.active_1}, 2'b11);
      send_bits(COMMA, COMMA, 0, 0);
`ifdef SERIALTOPARA_REALIGN_EN
      check("slip edge 73", {bus.active_0, bus.active_1, bus.valid_0, bus.valid_1,
            bus.stb_0, bus.stb_1}, 6'b0);
`else
      check("slip edge 73", {bus.active_0, bus.active_1}, 2'b11);
`endif
      repeat (3) send_byte(COMMA, COMMA);
      send_bits(COMMA, COMMA, 7, 1);
`ifdef SERIALTOPARA_REALIGN_EN
      check("slip edge 104", {bus.active_0, bus.active_1}, 2'b00);
`else
      check("slip edge 104", {bus.active_0, bus.active_1}, 2'b11);
`endif
      send_bits(COMMA, COMMA, 0, 0);
      check("slip edge 105", {bus.active_0, bus.active_1}, 2'b11);

      // Three-bit phase offset with known data, then randomized offsets and data.
      data0 = '{8'hCC, 8'hBB, 8'h00, 8'hBC, 8'h1F, 8'hCC};
      data1 = '{8'hBB, 8'hCC, 8'hBC, 8'h01, 8'hBB, 8'h10};
      run_stream(3, 3);
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < ND; j++) begin
            data0[j] = rand_data();
            data1[j] = rand_data();
         end
         run_stream($urandom_range(0, 7), $urandom_range(0, 7));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
